// File: rtl/cmac_rx_pkt_checker.sv
// Receive-side frame checker for a CMAC AXI-Stream port: verifies the incrementing byte
// pattern, the tkeep shape, the frame error flag and the frame length, and counts good and bad packets.
//
// state | meaning
// IDLE  | waiting for alignment and enable; beats ignored
// RUN   | sampling beats and checking packets
// DONE  | finite run complete; beats ignored until clear
module cmac_rx_pkt_checker #(
  parameter int PKT_NUM  = 1000,
  parameter int PKT_SIZE = 8192
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx_aligned,
  input  logic         ctl_chk_enable,
  input  logic         send_continuous_pkts,
  input  logic         clear,
  input  logic         rx_axis_tvalid,
  input  logic [511:0] rx_axis_tdata,
  input  logic [63:0]  rx_axis_tkeep,
  input  logic         rx_axis_tlast,
  input  logic         rx_axis_tuser,
  output logic [31:0]  good_pkt_count,
  output logic [31:0]  bad_pkt_count,
  output logic [47:0]  rx_byte_count,
  output logic         rx_busy_led,
  output logic         rx_done_led,
  output logic         rx_err_led
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic        in_pkt_q, err_q;
  logic [7:0]  seed_q, beat_cnt_q;
  logic        s1_valid_q, s1_err_q, s1_drop_q, s1_sat_q;
  logic [7:0]  s1_cnt_q;
  logic [6:0]  s1_pop_q;
  logic        s2_valid_q, s2_bad_q;
  logic [15:0] s2_len_q;

  logic        beat_ok, sop, drop, keep_err, beat_err, err_acc;
  logic [31:0] total, total_next;
  logic [7:0]  pending_idx, cur_seed, beat_idx, base;
  logic [63:0] mism;
  logic [15:0] s1_len;

  assign total       = good_pkt_count + bad_pkt_count;
  assign total_next  = total + {31'd0, s2_valid_q};
  assign beat_ok     = (state_q == RUN) && rx_aligned && rx_axis_tvalid && !clear;
  assign drop        = (state_q == RUN) && !rx_aligned && in_pkt_q && !clear;
  assign sop         = !in_pkt_q;
  // Packets still in the pipeline already own a seed, so count them toward the next one.
  assign pending_idx = total[7:0] + {7'd0, s1_valid_q} + {7'd0, s2_valid_q};
  assign cur_seed    = sop ? pending_idx : seed_q;
  assign beat_idx    = sop ? 8'd0 : beat_cnt_q;
  assign base        = cur_seed + {beat_idx[1:0], 6'd0};

  for (genvar k = 0; k < 64; k++) begin : g_cmp
    assign mism[k] = rx_axis_tkeep[k] && (rx_axis_tdata[8*k +: 8] != (base + 8'(k)));
  end

  // A legal last-beat keep is 2^n-1 with n >= 1.
  assign keep_err = rx_axis_tlast ?
                    ((rx_axis_tkeep == 64'd0) || ((rx_axis_tkeep & (rx_axis_tkeep + 64'd1)) != 64'd0)) :
                    (rx_axis_tkeep != '1);
  assign beat_err = (|mism) || keep_err || (rx_axis_tlast && rx_axis_tuser);
  assign err_acc  = (sop ? 1'b0 : err_q) || beat_err;
  assign s1_len   = {2'd0, s1_cnt_q, 6'd0} + {9'd0, s1_pop_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rx_aligned && ctl_chk_enable) state_d = RUN;
      RUN: begin
        if (!rx_aligned) state_d = IDLE;
        else if (!send_continuous_pkts && (total_next >= 32'(PKT_NUM))) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_q   <= 1'b0;
      err_q      <= 1'b0;
      seed_q     <= 8'd0;
      beat_cnt_q <= 8'd0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_drop_q  <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_cnt_q   <= 8'd0;
      s1_pop_q   <= 7'd0;
      s2_valid_q <= 1'b0;
      s2_bad_q   <= 1'b0;
      s2_len_q   <= 16'd0;
    end else if (clear) begin
      in_pkt_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= (beat_ok && rx_axis_tlast) || drop;
      s1_err_q   <= drop || err_acc;
      s1_drop_q  <= drop;
      s1_sat_q   <= (beat_idx == 8'hFF);
      s1_cnt_q   <= beat_idx;
      s1_pop_q   <= 7'($countones(rx_axis_tkeep));
      if (beat_ok) begin
        in_pkt_q   <= !rx_axis_tlast;
        err_q      <= err_acc;
        beat_cnt_q <= (beat_idx == 8'hFF) ? 8'hFF : beat_idx + 8'd1;
        if (sop) seed_q <= cur_seed;
      end else if (state_q != RUN || !rx_aligned) begin
        in_pkt_q <= 1'b0;
      end
      s2_valid_q <= s1_valid_q;
      s2_bad_q   <= s1_err_q || s1_sat_q || (s1_len != 16'(PKT_SIZE));
      s2_len_q   <= s1_drop_q ? 16'd0 : s1_len;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_pkt_count <= 32'd0;
      bad_pkt_count  <= 32'd0;
      rx_byte_count  <= 48'd0;
      rx_err_led     <= 1'b0;
    end else if (clear) begin
      good_pkt_count <= 32'd0;
      bad_pkt_count  <= 32'd0;
      rx_byte_count  <= 48'd0;
      rx_err_led     <= 1'b0;
    end else if (s2_valid_q) begin
      rx_byte_count <= rx_byte_count + {32'd0, s2_len_q};
      if (s2_bad_q) begin
        bad_pkt_count <= bad_pkt_count + 32'd1;
        rx_err_led    <= 1'b1;
      end else begin
        good_pkt_count <= good_pkt_count + 32'd1;
      end
    end
  end

  assign rx_busy_led = (state_q == RUN);
  assign rx_done_led = (state_q == DONE);

endmodule

// File: tb/tb_cmac_rx_pkt_checker.sv
// Bench for cmac_rx_pkt_checker: three instances with different parameters share one stream;
// only the enabled instance runs. Packet completions are checked by a scoreboard monitor.
module tb_cmac_rx_pkt_checker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_aligned = 1'b0, cont = 1'b0, clear = 1'b0;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [511:0] tdata = '0;
  logic [63:0]  tkeep = '0;
  logic [2:0]   en = 3'b000;

  logic [31:0] good [3];
  logic [31:0] bad  [3];
  logic [47:0] bytes[3];
  logic        busy [3];
  logic        done [3];
  logic        errl [3];

  always #5 clk = ~clk;

  cmac_rx_pkt_checker #(.PKT_NUM(4), .PKT_SIZE(128)) u0 (
    .clk(clk), .reset_n(reset_n), .rx_aligned(rx_aligned), .ctl_chk_enable(en[0]),
    .send_continuous_pkts(cont), .clear(clear), .rx_axis_tvalid(tvalid), .rx_axis_tdata(tdata),
    .rx_axis_tkeep(tkeep), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .good_pkt_count(good[0]), .bad_pkt_count(bad[0]), .rx_byte_count(bytes[0]),
    .rx_busy_led(busy[0]), .rx_done_led(done[0]), .rx_err_led(errl[0]));

  cmac_rx_pkt_checker #(.PKT_NUM(1000), .PKT_SIZE(100)) u1 (
    .clk(clk), .reset_n(reset_n), .rx_aligned(rx_aligned), .ctl_chk_enable(en[1]),
    .send_continuous_pkts(cont), .clear(clear), .rx_axis_tvalid(tvalid), .rx_axis_tdata(tdata),
    .rx_axis_tkeep(tkeep), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .good_pkt_count(good[1]), .bad_pkt_count(bad[1]), .rx_byte_count(bytes[1]),
    .rx_busy_led(busy[1]), .rx_done_led(done[1]), .rx_err_led(errl[1]));

  cmac_rx_pkt_checker #(.PKT_NUM(2), .PKT_SIZE(64)) u2 (
    .clk(clk), .reset_n(reset_n), .rx_aligned(rx_aligned), .ctl_chk_enable(en[2]),
    .send_continuous_pkts(cont), .clear(clear), .rx_axis_tvalid(tvalid), .rx_axis_tdata(tdata),
    .rx_axis_tkeep(tkeep), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .good_pkt_count(good[2]), .bad_pkt_count(bad[2]), .rx_byte_count(bytes[2]),
    .rx_busy_led(busy[2]), .rx_done_led(done[2]), .rx_err_led(errl[2]));

  typedef struct {
    int     inst;
    int     good;
    int     bad;
    longint bytes;
    bit     err;
    int     cyc;
  } exp_t;

  exp_t   sbq[$];
  int     n_checks = 0, n_pass = 0;
  int     cyc = 0;
  int     m_good[3], m_bad[3];
  longint m_bytes[3];
  bit     m_err[3];
  logic [31:0] prev_tot[3];
  bit     saw_done2 = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) prev_tot[i] = '0;
  end

  // Monitor: any change of good+bad on an instance is one packet completion.
  always @(negedge clk) begin
    if (done[2]) saw_done2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] tot;
      tot = good[i] + bad[i];
      if (tot != prev_tot[i]) begin
        if (tot != 32'd0) begin
          n_checks++;
          if (sbq.size() == 0) begin
            $display("FAIL unexpected_update: inst %0d good %0d bad %0d", i, good[i], bad[i]);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (e.inst == i && good[i] == 32'(e.good) && bad[i] == 32'(e.bad) &&
                bytes[i] == 48'(e.bytes) && errl[i] == e.err && cyc == e.cyc) begin
              n_pass++;
            end else begin
              $display("FAIL pkt_update: got inst %0d good %0d bad %0d bytes %0d err %0d cyc %0d, expected inst %0d good %0d bad %0d bytes %0d err %0d cyc %0d",
                       i, good[i], bad[i], bytes[i], errl[i], cyc,
                       e.inst, e.good, e.bad, e.bytes, e.err, e.cyc);
            end
          end
        end
        prev_tot[i] = tot;
      end
    end
  end

  function automatic logic [511:0] pat(input int seed, input int b);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'((seed + 64*b + k) & 255);
    return d;
  endfunction

  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input bit last, input bit user);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = last; tuser = user;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after the edge that closes a packet; the counters follow two edges later.
  task automatic push(input int inst, input bit ok, input int len);
    exp_t e;
    if (ok) m_good[inst]++;
    else begin m_bad[inst]++; m_err[inst] = 1'b1; end
    m_bytes[inst] += len;
    e.inst = inst; e.good = m_good[inst]; e.bad = m_bad[inst];
    e.bytes = m_bytes[inst]; e.err = m_err[inst]; e.cyc = cyc + 2;
    sbq.push_back(e);
  endtask

  task automatic send_frame(input int inst, input int nb, input logic [63:0] lk, input int bad_beat,
                            input bit user, input int gap, input bit ok);
    int seed;
    logic [511:0] d;
    seed = (m_good[inst] + m_bad[inst]) % 256;
    for (int b = 0; b < nb; b++) begin
      d = pat(seed, b);
      if (b == bad_beat) d[47:40] = d[47:40] ^ 8'hA5;
      drive_beat(d, (b == nb-1) ? lk : '1, b == nb-1, user && (b == nb-1));
      if (gap > 0 && b == 0 && nb > 1) idle(gap);
    end
    push(inst, ok, 64*(nb-1) + $countones(lk));
  endtask

  task automatic do_clear();
    en = 3'b000;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_good[i] = 0; m_bad[i] = 0; m_bytes[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_good[i] = 0; m_bad[i] = 0; m_bytes[i] = 0; m_err[i] = 1'b0;
    end
    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_good%0d", i), good[i], 0);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_done%0d", i), done[i], 0);
    end
    chk("rst_err0", errl[0], 0);
    chk("rst_bytes0", bytes[0], 0);
    reset_n = 1'b1;
    rx_aligned = 1'b1;
    idle(2);
    chk("idle_no_enable", busy[0], 0);

    // Finite run of four 2-beat frames into DONE, one with a mid-packet gap.
    en[0] = 1'b1;
    idle(1);
    chk("busy_run", busy[0], 1);
    send_frame(0, 2, '1, -1, 0, 0, 1);
    send_frame(0, 2, '1, -1, 0, 3, 1);
    send_frame(0, 2, '1, -1, 0, 0, 1);
    send_frame(0, 2, '1, -1, 0, 0, 1);
    idle(1);
    chk("done_not_yet", done[0], 0);
    idle(1);
    chk("done_led", done[0], 1);
    chk("busy_after_done", busy[0], 0);
    drive_beat(pat(4, 0), '1, 0, 0);
    drive_beat(pat(4, 1), '1, 1, 0);
    idle(4);
    chk("done_ignores_good", good[0], 4);
    chk("done_ignores_bytes", bytes[0], 512);
    chk("done_holds", done[0], 1);
    do_clear();
    chk("clear_done", done[0], 0);
    chk("clear_good", good[0], 0);
    chk("clear_bytes", bytes[0], 0);

    // Length / keep / tuser / alignment-loss cases on the 100-byte instance.
    en[1] = 1'b1;
    idle(1);
    send_frame(1, 2, 64'h0000_000F_FFFF_FFFF, -1, 0, 0, 1);
    send_frame(1, 2, 64'h0000_0000_0000_0F0F, -1, 0, 0, 0);
    send_frame(1, 2, 64'h0000_000F_FFFF_FFFF, -1, 1, 0, 0);
    send_frame(1, 2, '1, -1, 0, 0, 0);
    idle(3);
    chk("err_led_set", errl[1], 1);
    drive_beat(pat(4, 0), '1, 0, 0);
    rx_aligned = 1'b0;
    idle(1);
    push(1, 0, 0);
    chk("drop_busy", busy[1], 0);
    rx_aligned = 1'b1;
    idle(1);
    chk("realign_busy", busy[1], 1);
    send_frame(1, 2, 64'h0000_000F_FFFF_FFFF, -1, 0, 0, 1);
    idle(3);
    chk("u1_good", good[1], 2);
    chk("u1_bad", bad[1], 4);
    chk("u1_bytes", bytes[1], 500);
    do_clear();

    // Pattern corruption followed by a clean frame; error LED stays sticky.
    en[0] = 1'b1;
    idle(1);
    send_frame(0, 2, '1, 1, 0, 0, 0);
    send_frame(0, 2, '1, -1, 0, 0, 1);
    idle(3);
    chk("sticky_err", errl[0], 1);
    do_clear();
    chk("clear_err", errl[0], 0);

    // Continuous mode: 300 back-to-back single-beat frames, seed wraps past 255.
    cont = 1'b1;
    en[2] = 1'b1;
    idle(1);
    for (int i = 0; i < 300; i++) send_frame(2, 1, '1, -1, 0, 0, 1);
    idle(3);
    chk("cont_good", good[2], 300);
    chk("cont_bad", bad[2], 0);
    chk("cont_never_done", saw_done2, 0);
    chk("cont_busy", busy[2], 1);
    cont = 1'b0;
    idle(1);
    chk("cont_off_done", done[2], 1);
    do_clear();

    // Async reset mid-frame, then clear coinciding with tlast.
    en[0] = 1'b1;
    idle(1);
    send_frame(0, 2, '1, -1, 0, 0, 1);
    idle(3);
    drive_beat(pat(1, 0), '1, 0, 0);
    reset_n = 1'b0;
    #2;
    chk("arst_good", good[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_bytes", bytes[0], 0);
    for (int i = 0; i < 3; i++) begin
      m_good[i] = 0; m_bad[i] = 0; m_bytes[i] = 0; m_err[i] = 1'b0;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tvalid = 1'b1; tdata = pat(0, 0); tkeep = '1; tlast = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    chk("rel_busy", busy[0], 1);
    drive_beat(pat(0, 0), '1, 0, 0);
    clear = 1'b1;
    drive_beat(pat(0, 1), '1, 1, 0);
    clear = 1'b0;
    chk("clear_tlast_idle", busy[0], 0);
    idle(4);
    chk("clear_tlast_good", good[0], 0);
    chk("clear_tlast_bad", bad[0], 0);
    send_frame(0, 2, '1, -1, 0, 0, 1);
    idle(4);
    chk("post_clear_good", good[0], 1);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmac_rx_pkt_checker.md
CMAC_RX_PKT_CHECKER -- requirements
Module: cmac_rx_pkt_checker

Interface
REQ-001 Parameter PKT_NUM, default 1000, number of packets in a finite check run (1..65535).
REQ-002 Parameter PKT_SIZE, default 8192, expected frame length in bytes (64..16000).
REQ-003 clk  input  1  CMAC RX user clock; all logic in this domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx_aligned  input  1  CMAC stat_rx_aligned, synchronous to clk.
REQ-006 ctl_chk_enable  input  1  arm checker.
REQ-007 send_continuous_pkts  input  1  1 = never enter DONE.
REQ-008 clear  input  1  synchronous clear pulse.
REQ-009 rx_axis_tvalid  input  1  beat valid; no tready exists, every valid beat is consumed.
REQ-010 rx_axis_tdata  input  512  beat data, byte k at bits [8k+7:8k].
REQ-011 rx_axis_tkeep  input  64  byte enables.
REQ-012 rx_axis_tlast  input  1  last beat of frame.
REQ-013 rx_axis_tuser  input  1  CMAC frame error, valid with tlast.
REQ-014 good_pkt_count  output  32  packets passing all checks.
REQ-015 bad_pkt_count  output  32  packets failing any check.
REQ-016 rx_byte_count  output  48  kept bytes of all completed packets.
REQ-017 rx_busy_led  output  1  high in RUN.
REQ-018 rx_done_led  output  1  high in DONE.
REQ-019 rx_err_led  output  1  sticky, set on first bad packet.

Function
REQ-020 States SHALL be IDLE, RUN, DONE; only RUN samples beats.
REQ-021 IDLE->RUN when rx_aligned=1 and ctl_chk_enable=1, next cycle.
REQ-022 RUN->DONE when good+bad reaches PKT_NUM and send_continuous_pkts=0; beats in DONE ignored.
REQ-023 RUN->IDLE when rx_aligned falls; an open packet is discarded and counted once in bad_pkt_count.
REQ-024 In RUN, first valid beat after IDLE or after a tlast beat is SOP; seed = (good+bad)[7:0] latched at SOP.
REQ-025 Expected byte k of beat b (b from 0) SHALL be (seed + 64*b + k) mod 256; compared only where tkeep[k]=1.
REQ-026 Packet bad if any: pattern mismatch; non-last beat tkeep != all ones; last-beat tkeep not contiguous from bit 0 or zero; tuser=1 at tlast; length != PKT_SIZE.
REQ-027 Length = 64*(beats-1) + popcount(last tkeep); beat counter 8 bits, saturating at 255 (saturation forces length error).
REQ-028 Checking pipelined 2 stages: counters and rx_err_led update exactly 2 cycles after the tlast beat.
REQ-029 Back-to-back frames (tlast then SOP next cycle, or single-beat frames every cycle) SHALL be checked without loss.
REQ-030 Counters wrap modulo 2^width; no saturation.
REQ-031 DONE->IDLE only on clear.
REQ-032 clear SHALL zero counters and rx_err_led, abort any open packet without counting it, force IDLE; clear beats in-flight pipeline updates in the same cycle.
REQ-033 tvalid=0 mid-packet SHALL hold packet state (gaps allowed).

Reset
REQ-034 reset_n=0 SHALL asynchronously force IDLE, all counters 0, all LEDs 0, pipeline valids 0.
REQ-035 Deassertion takes effect on the first clk edge with reset_n=1; no beat sampled on that edge.

Verification
REQ-036 PKT_NUM=4, PKT_SIZE=128, 4 correct 2-beat frames seeds 0..3 -> good=4, bad=0, bytes=512, rx_done_led=1 two cycles after last tlast.
REQ-037 PKT_SIZE=100, frame with last tkeep=64'h0000_000F_FFFF_FFFF -> good+1; last tkeep=64'h0F0F -> bad+1, rx_err_led=1.
REQ-038 Byte 5 of beat 1 corrupted, then clean frame with seed 1 -> bad=1, good=1, rx_err_led stays 1.
REQ-039 rx_aligned dropped after beat 0 of a frame -> bad+1, state IDLE, busy=0; re-align -> RUN.
REQ-040 send_continuous_pkts=1, PKT_NUM=2, 300 back-to-back single-beat frames (PKT_SIZE=64) -> good=300, seed wraps at 256, never DONE.
REQ-041 reset_n pulsed low mid-frame, and clear asserted same cycle as tlast -> counters 0, IDLE, no count for that frame.
